// File: rtl/share_pkg.sv
// Shared types and helpers for the first-order masking encoder.
package share_pkg;

  typedef enum logic [1:0] {
    UNSEEDED = 2'd0,
    WARMUP   = 2'd1,
    RUN      = 2'd2
  } state_t;

  // Widest LFSR the step helper supports; narrower states are zero-extended.
  localparam int unsigned LFSR_MAX_W = 64;

  // x^32 + x^22 + x^2 + x + 1
  localparam logic [31:0] DEFAULT_POLY = 32'h8020_0003;

  // One Galois step: shift right, fold the taps back in when a 1 falls out.
  // Upper bits beyond the real LFSR width stay zero because zeros shift in.
  function automatic logic [LFSR_MAX_W-1:0] lfsr_step(
    input logic [LFSR_MAX_W-1:0] s,
    input logic [LFSR_MAX_W-1:0] poly
  );
    logic [LFSR_MAX_W-1:0] n;
    n = s >> 1;
    if (s[0]) n = n ^ poly;
    return n;
  endfunction

endpackage

// File: rtl/share_lfsr.sv
// Seedable Galois LFSR; one advance applies WIDTH steps in a single clock.
module share_lfsr
  import share_pkg::*;
#(
  parameter int unsigned       LFSR_W = 32,
  parameter int unsigned       WIDTH  = 8,
  parameter logic [LFSR_W-1:0] POLY   = LFSR_W'(DEFAULT_POLY)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [LFSR_W-1:0] seed,
  input  logic              advance,
  output logic [LFSR_W-1:0] state
);

  logic [LFSR_MAX_W-1:0] wide;
  logic [LFSR_MAX_W-1:0] polyWide;
  logic [LFSR_W-1:0]     advanced;
  logic                  unusedWideHi;

  // Unrolled WIDTH-step advance of the current state.
  always_comb begin
    wide     = '0;
    polyWide = '0;
    wide[LFSR_W-1:0]     = state;
    polyWide[LFSR_W-1:0] = POLY;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      wide = lfsr_step(wide, polyWide);
    end
    advanced = wide[LFSR_W-1:0];
  end

  assign unusedWideHi = ^wide;

  // State register: a seed load takes priority over an advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= '0;
    end else if (load) begin
      state <= seed;
    end else if (advance) begin
      state <= advanced;
    end
  end

endmodule

// File: rtl/share_encoder.sv
// Streaming first-order Boolean masking encoder: out_a = data ^ mask, out_b = mask.
module share_encoder #(
  parameter int unsigned       WIDTH  = 8,
  parameter int unsigned       LFSR_W = 32,
  parameter logic [LFSR_W-1:0] POLY   = LFSR_W'(share_pkg::DEFAULT_POLY),
  parameter int unsigned       WARMUP = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed,
  output logic              seed_err,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_a,
  output logic [WIDTH-1:0]  out_b
);

  localparam int unsigned CW = (WARMUP > 1) ? $clog2(WARMUP) : 1;

  share_pkg::state_t state, stateNext;
  logic [CW-1:0]     warmCnt, warmCntNext;
  logic [LFSR_W-1:0] lfsrState;
  logic              lfsrLoad;
  logic              lfsrAdvance;
  logic              seedNonZero;
  logic              accept;
  logic              readyInt;
  logic [WIDTH-1:0]  mask;
  logic [WIDTH-1:0]  outA, outB;
  logic              outValid;
  logic              seedErr;
  logic              unusedLfsr;

  share_lfsr #(
    .LFSR_W (LFSR_W),
    .WIDTH  (WIDTH),
    .POLY   (POLY)
  ) uLfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (lfsrLoad),
    .seed    (seed),
    .advance (lfsrAdvance),
    .state   (lfsrState)
  );

  assign seedNonZero = |seed;
  assign lfsrLoad    = seed_load && seedNonZero;
  assign mask        = lfsrState[WIDTH-1:0];
  assign unusedLfsr  = ^lfsrState;

  // A seed strobe blocks acceptance in its own cycle; a held pair blocks until popped.
  assign readyInt = (state == share_pkg::RUN) && !seed_load && (!outValid || out_ready);
  assign accept   = in_valid && readyInt;

  // FSM state and warm-up counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= share_pkg::UNSEEDED;
      warmCnt <= '0;
    end else begin
      state   <= stateNext;
      warmCnt <= warmCntNext;
    end
  end

  // Next-state, warm-up counting and LFSR advance control.
  always_comb begin
    stateNext   = state;
    warmCntNext = warmCnt;
    lfsrAdvance = 1'b0;
    if (seed_load) begin
      if (seedNonZero) begin
        stateNext   = share_pkg::WARMUP;
        warmCntNext = '0;
      end else begin
        stateNext = share_pkg::UNSEEDED;
      end
    end else begin
      unique case (state)
        share_pkg::WARMUP: begin
          lfsrAdvance = 1'b1;
          warmCntNext = warmCnt + CW'(1);
          if (warmCnt == CW'(WARMUP - 1)) stateNext = share_pkg::RUN;
        end
        share_pkg::RUN:      lfsrAdvance = accept;
        share_pkg::UNSEEDED: lfsrAdvance = 1'b0;
        default:             stateNext   = share_pkg::UNSEEDED;
      endcase
    end
  end

  // Output share registers and the zero-seed error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outA     <= '0;
      outB     <= '0;
      outValid <= 1'b0;
      seedErr  <= 1'b0;
    end else begin
      seedErr <= seed_load && !seedNonZero;
      if (accept) begin
        outA     <= in_data ^ mask;
        outB     <= mask;
        outValid <= 1'b1;
      end else if (outValid && out_ready) begin
        outValid <= 1'b0;
      end
    end
  end

  assign in_ready  = readyInt;
  assign out_valid = outValid;
  assign out_a     = outA;
  assign out_b     = outB;
  assign seed_err  = seedErr;

endmodule
